// File: rtl/shift_pkg.sv
// Shared sizing for the buffer loader and its shift datapath: entry width, depth, buffer count, empty marker.
package shift_pkg;
  localparam int DEF_ENTRY_W = 3;
  localparam int DEF_DEPTH   = 6;
  localparam int NUM_BUF     = 4;
  localparam int SEL_W       = 2;
  localparam int EMPTY_ENTRY = 0;

  typedef logic [SEL_W-1:0] buf_idx_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit searching ptr, ptr+1, ... modulo NUM_BUF. Purely combinational.
module rr_pick
  import shift_pkg::*;
(
  input  logic [NUM_BUF-1:0] req,
  input  buf_idx_t           ptr,
  output buf_idx_t           gnt,
  output logic               any_gnt
);

  buf_idx_t idx;

  // Walk from the farthest offset back to ptr so the closest requester wins.
  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        gnt     = idx;
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_loader.sv
// Four shift buffers loaded by a valid/ready writer and drained head-first in round-robin order.
// Optional BUFFER_LOADER_STATS_EN adds a saturating drop counter (refused or zero-valued writes).
module buffer_loader
  import shift_pkg::*;
#(
  parameter int ENTRY_W = DEF_ENTRY_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [ENTRY_W-1:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_sel,
  output logic [ENTRY_W-1:0]       out_data,
  output logic [ENTRY_W*DEPTH-1:0] buffer1_o,
  output logic [ENTRY_W*DEPTH-1:0] buffer2_o,
  output logic [ENTRY_W*DEPTH-1:0] buffer3_o,
  output logic [ENTRY_W*DEPTH-1:0] buffer4_o,
`ifdef BUFFER_LOADER_STATS_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic [NUM_BUF-1:0]       full,
  output logic [NUM_BUF-1:0]       empty
);

  localparam int BUF_W = ENTRY_W * DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BUF_W-1:0] buf_q [NUM_BUF];
  logic [BUF_W-1:0] buf_d [NUM_BUF];
  logic [CNT_W-1:0] cnt_q [NUM_BUF];
  logic [CNT_W-1:0] cnt_d [NUM_BUF];
  buf_idx_t         rr_q, rr_d;

  logic [NUM_BUF-1:0] req_mask;
  buf_idx_t           pick_sel;
  logic               pick_vld;
  logic               pop;
  logic               wr_en;

  always_comb begin
    for (int b = 0; b < NUM_BUF; b++) begin
      full[b]  = (cnt_q[b] == CNT_W'(DEPTH));
      empty[b] = (cnt_q[b] == '0);
    end
  end

  assign req_mask = ~empty;
  assign in_ready = !full[in_sel];

  rr_pick u_rr_pick (
    .req     (req_mask),
    .ptr     (rr_q),
    .gnt     (pick_sel),
    .any_gnt (pick_vld)
  );

  assign out_valid = pick_vld;
  assign out_sel   = pick_vld ? pick_sel : '0;
  assign out_data  = pick_vld ? buf_q[pick_sel][ENTRY_W-1:0] : '0;

  assign pop   = pick_vld && out_ready;
  assign wr_en = in_valid && in_ready && (in_data != ENTRY_W'(EMPTY_ENTRY));

  // Pop shifts first, so a same-buffer write lands at the post-shift fill level.
  always_comb begin
    rr_d = rr_q;
    if (pop) begin
      rr_d = pick_sel + 1'b1;
    end
    for (int b = 0; b < NUM_BUF; b++) begin
      buf_d[b] = buf_q[b];
      cnt_d[b] = cnt_q[b];
      if (pop && (pick_sel == SEL_W'(b))) begin
        buf_d[b] = buf_q[b] >> ENTRY_W;
        cnt_d[b] = cnt_q[b] - 1'b1;
      end
      if (wr_en && (in_sel == SEL_W'(b))) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (cnt_d[b] == CNT_W'(k)) begin
            buf_d[b][k*ENTRY_W +: ENTRY_W] = in_data;
          end
        end
        cnt_d[b] = cnt_d[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BUF; b++) begin
        buf_q[b] <= '0;
        cnt_q[b] <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BUF; b++) begin
        buf_q[b] <= buf_d[b];
        cnt_q[b] <= cnt_d[b];
      end
      rr_q <= rr_d;
    end
  end

  assign buffer1_o = buf_q[0];
  assign buffer2_o = buf_q[1];
  assign buffer3_o = buf_q[2];
  assign buffer4_o = buf_q[3];

`ifdef BUFFER_LOADER_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && (!in_ready || (in_data == ENTRY_W'(EMPTY_ENTRY))) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_buffer_loader.sv
// Directed bench for buffer_loader: reset state, fill/full, round-robin drain, same-buffer write+pop, zero writes, mid-stream reset.
module tb_buffer_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [2:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
  logic [2:0]  out_data;
  logic [17:0] buffer1_o, buffer2_o, buffer3_o, buffer4_o;
  logic [3:0]  full, empty;
`ifdef BUFFER_LOADER_STATS_EN
  logic [7:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  buffer_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_data  (out_data),
    .buffer1_o (buffer1_o),
    .buffer2_o (buffer2_o),
    .buffer3_o (buffer3_o),
    .buffer4_o (buffer4_o),
`ifdef BUFFER_LOADER_STATS_EN
    .drop_cnt  (drop_cnt),
`endif
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [2:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    step();
    in_valid = 1'b0;
    in_sel   = 2'd0;
    in_data  = 3'd0;
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " buf1"}, 32'(buffer1_o), 32'd0);
    check({tag, " buf2"}, 32'(buffer2_o), 32'd0);
    check({tag, " buf3"}, 32'(buffer3_o), 32'd0);
    check({tag, " buf4"}, 32'(buffer4_o), 32'd0);
    check({tag, " full"}, 32'(full), 32'h0);
    check({tag, " empty"}, 32'(empty), 32'hF);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_sel"}, 32'(out_sel), 32'd0);
    check({tag, " out_data"}, 32'(out_data), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 3'd0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_reset_state("rst");
`ifdef BUFFER_LOADER_STATS_EN
    check("rst drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Write 5,6,7 into buffer1; first write must not bypass to the output.
    in_valid = 1'b1; in_sel = 2'd0; in_data = 3'd5;
    #1;
    check("nobypass out_valid", 32'(out_valid), 32'd0);
    step();
    check("lat1 out_data", 32'(out_data), 32'd5);
    in_valid = 1'b0;
    wr(2'd0, 3'd6);
    wr(2'd0, 3'd7);
    check("fill buf1", 32'(buffer1_o), 32'o000765);
    check("fill empty", 32'(empty), 32'b1110);
    check("fill out_data", 32'(out_data), 32'd5);
    check("fill out_sel", 32'(out_sel), 32'd0);

    // Fill buffer3 with six 1s; seventh write refused.
    do_reset();
    for (int i = 0; i < 6; i++) wr(2'd2, 3'd1);
    check("full vec", 32'(full), 32'b0100);
    in_sel = 2'd2;
    #1;
    check("full in_ready", 32'(in_ready), 32'd0);
    wr(2'd2, 3'd1);
    check("full buf3", 32'(buffer3_o), 32'o111111);
    check("full out_sel", 32'(out_sel), 32'd2);
    check("other in_ready", 32'(in_ready), 32'd1);

    // One entry in buffers 1,2,4; drain in round-robin order.
    do_reset();
    wr(2'd0, 3'd1);
    wr(2'd1, 3'd2);
    wr(2'd3, 3'd4);
    out_ready = 1'b1;
    #1;
    check("rr0 sel", 32'(out_sel), 32'd0);
    check("rr0 data", 32'(out_data), 32'd1);
    step();
    check("rr1 sel", 32'(out_sel), 32'd1);
    check("rr1 data", 32'(out_data), 32'd2);
    step();
    check("rr2 sel", 32'(out_sel), 32'd3);
    check("rr2 data", 32'(out_data), 32'd4);
    step();
    check("rr done valid", 32'(out_valid), 32'd0);
    check("rr done data", 32'(out_data), 32'd0);
    out_ready = 1'b0;

    // Pointer moves past the popped buffer; head stable under backpressure.
    do_reset();
    wr(2'd0, 3'd1);
    wr(2'd1, 3'd3);
    check("hold sel", 32'(out_sel), 32'd0);
    check("hold data", 32'(out_data), 32'd1);
    wr(2'd0, 3'd2);
    check("hold2 data", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    step();
    check("ptr sel1", 32'(out_sel), 32'd1);
    check("ptr data3", 32'(out_data), 32'd3);
    step();
    check("ptr wrap sel0", 32'(out_sel), 32'd0);
    check("ptr wrap data2", 32'(out_data), 32'd2);
    out_ready = 1'b0;

    // Buffer2 holds 3,4; write 5 with simultaneous pop.
    do_reset();
    wr(2'd1, 3'd3);
    wr(2'd1, 3'd4);
    out_ready = 1'b1;
    wr(2'd1, 3'd5);
    out_ready = 1'b0;
    #1;
    check("wrpop buf2", 32'(buffer2_o), 32'o000054);
    out_ready = 1'b1;
    #1;
    check("wrpop head4", 32'(out_data), 32'd4);
    step();
    check("wrpop head5", 32'(out_data), 32'd5);
    step();
    check("wrpop empty", 32'(empty), 32'hF);
    out_ready = 1'b0;

    // Zero-valued write is accepted but discarded.
    do_reset();
    wr(2'd0, 3'd3);
    wr(2'd0, 3'd0);
    check("zero buf1", 32'(buffer1_o), 32'd3);
    check("zero empty", 32'(empty), 32'b1110);
`ifdef BUFFER_LOADER_STATS_EN
    check("zero drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Reset mid-stream with write and pop active.
    wr(2'd2, 3'd6);
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 3'd7; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; in_data = 3'd0; out_ready = 1'b0;
    #1;
    check_reset_state("midrst");
`ifdef BUFFER_LOADER_STATS_EN
    check("midrst drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/buffer_loader.md
BUFFER_LOADER -- requirements
Module: buffer_loader

Interface
REQ-001 SHALL have parameter ENTRY_W, default 3, bit width of one entry.
REQ-002 SHALL have parameter DEPTH, default 6, entries per buffer; packed buffer width is ENTRY_W*DEPTH (18).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  write request.
REQ-006 SHALL have port in_ready  output  1  write accepted when in_valid && in_ready.
REQ-007 SHALL have port in_sel  input  2  target buffer, 0..3 selects buffer1..buffer4.
REQ-008 SHALL have port in_data  input  ENTRY_W  entry value; 0 is reserved as the empty marker.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer takes head when out_valid && out_ready.
REQ-011 SHALL have port out_sel  output  2  buffer index of presented head.
REQ-012 SHALL have port out_data  output  ENTRY_W  presented head entry.
REQ-013 SHALL have ports buffer1_o..buffer4_o  output  18 each  packed contents; entry 0 (head) at bits [2:0], entry k at [3k+2:3k].
REQ-014 SHALL have port full  output  4  bit i set when buffer i+1 holds DEPTH entries.
REQ-015 SHALL have port empty  output  4  bit i set when buffer i+1 holds 0 entries.

Function
REQ-016 SHALL keep a per-buffer count 0..DEPTH; unused slots SHALL read 0.
REQ-017 SHALL drive in_ready = !full[in_sel], purely from registered state (no path from out_ready).
REQ-018 SHALL, on accepted write with in_data != 0, store in_data at slot count of the selected buffer and increment count.
REQ-019 SHALL accept but discard writes with in_data == 0 (state unchanged).
REQ-020 SHALL drive out_valid when any buffer is non-empty; out_sel from round-robin pointer rr: first non-empty buffer searching rr, rr+1, ... mod 4.
REQ-021 SHALL drive out_data = bits [2:0] of the selected buffer; out_data = 0 when out_valid is low.
REQ-022 SHALL, on pop, shift the selected buffer right by ENTRY_W, fill the top slot with 0, decrement count, set rr = out_sel+1 mod 4.
REQ-023 SHALL hold rr unchanged when no pop occurs.
REQ-024 SHALL, on simultaneous write and pop of the same buffer, apply both: post-shift entries intact, new entry at slot count-1, count unchanged.
REQ-025 SHALL not bypass writes to output: an entry written at edge N is first visible on out_data after edge N (1-cycle latency).
REQ-026 SHALL present out_valid/out_sel/out_data stable while out_valid && !out_ready, unless a write changes no head (writes never alter a non-empty head).

Reset
REQ-027 SHALL, with rst high at a clock edge, clear all buffers and counts to 0, rr to 0, ignoring simultaneous writes/pops.
REQ-028 SHALL give after reset: buffer*_o = 0, full = 4'b0000, empty = 4'b1111, out_valid = 0, out_sel = 0, out_data = 0, in_ready = 1.

Configuration
REQ-029 SHALL, with BUFFER_LOADER_STATS_EN defined, add output drop_cnt (8 bits): increments (saturating at 255) per cycle with in_valid && (!in_ready || in_data == 0); cleared by rst.
REQ-030 SHALL, without BUFFER_LOADER_STATS_EN, omit drop_cnt and its logic entirely; all other behaviour identical.

Structure
REQ-031 SHALL take ENTRY_W, DEPTH, buffer count (4) and empty marker (0) from shared package shift_pkg, also used by shift.
REQ-032 SHALL instantiate one sub-module rr_pick (4-bit request mask + 2-bit pointer -> grant index + any-grant), combinational.

Verification
REQ-033 Reset, then write 5,6,7 to buffer1 -> buffer1_o = 18'o000765, empty = 4'b1110, out_data = 5, out_sel = 0.
REQ-034 Six writes of 1 to buffer3 with out_ready = 0 -> full[2] = 1, in_ready = 0 for in_sel = 2, seventh write dropped, buffer3_o = 18'o111111.
REQ-035 Buffers 1,2,4 each hold one entry (1,2,4), out_ready = 1 -> out_sel sequence 0,1,3, out_data 1,2,4, then out_valid = 0.
REQ-036 Buffer2 holds 3,4; write 5 to buffer2 with simultaneous pop -> buffer2_o = 18'o000054, count 2.
REQ-037 Write in_data = 0 -> no state change; with BUFFER_LOADER_STATS_EN, drop_cnt = 1.
REQ-038 Assert rst mid-stream with in_valid and out_ready high -> next cycle all outputs match REQ-028.
